// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the MIPS datapath ALU.
//   - alu_op_e : 4-bit operation select, encodings 0..15.
//   - ALU_OP_W : width of the operation select field.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_MUL  = 4'd2,
    ALU_DIV  = 4'd3,
    ALU_SHL  = 4'd4,
    ALU_SHR  = 4'd5,
    ALU_ROL  = 4'd6,
    ALU_ROR  = 4'd7,
    ALU_AND  = 4'd8,
    ALU_OR   = 4'd9,
    ALU_XOR  = 4'd10,
    ALU_NOR  = 4'd11,
    ALU_NAND = 4'd12,
    ALU_XNOR = 4'd13,
    ALU_GT   = 4'd14,
    ALU_EQ   = 4'd15
  } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu_comb.sv
// alu_comb
//   Purely combinational operation decode and datapath of the ALU.
//   Ports:
//     a      in   ALU_SIZE  operand A (unsigned)
//     b      in   ALU_SIZE  operand B (unsigned)
//     sel    in   alu_op_e  operation select
//     result out  ALU_SIZE  operation result, truncated to ALU_SIZE
//     carry  out  1         carry (ADD) / borrow (SUB), 0 for all other ops
module alu_comb
  import alu_pkg::*;
#(
  parameter int ALU_SIZE  = 8,
  parameter int SHIFT_BIT = 1
) (
  input  logic [ALU_SIZE-1:0] a,
  input  logic [ALU_SIZE-1:0] b,
  input  alu_op_e             sel,
  output logic [ALU_SIZE-1:0] result,
  output logic                carry
);

  // One extra bit on add/sub exposes carry-out and borrow directly.
  logic [ALU_SIZE:0]     sum;
  logic [ALU_SIZE:0]     diff;
  logic [2*ALU_SIZE-1:0] product;
  logic [ALU_SIZE-1:0]   quotient;
  logic [ALU_SIZE-1:0]   rol;
  logic [ALU_SIZE-1:0]   ror;

  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};
  assign product = {{ALU_SIZE{1'b0}}, a} * {{ALU_SIZE{1'b0}}, b};

  // Divide by zero saturates to all ones instead of relying on tool behaviour.
  assign quotient = (b == '0) ? '1 : (a / b);

  // Rotations are pure wiring: each output bit picks a fixed input bit.
  // With SHIFT_BIT=0 both mappings collapse to identity.
  genvar gi;
  generate
    for (gi = 0; gi < ALU_SIZE; gi++) begin : g_rot
      assign rol[gi] = a[(gi + ALU_SIZE - SHIFT_BIT) % ALU_SIZE];
      assign ror[gi] = a[(gi + SHIFT_BIT) % ALU_SIZE];
    end
  endgenerate

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (sel)
      ALU_ADD: begin
        result = sum[ALU_SIZE-1:0];
        carry  = sum[ALU_SIZE];
      end
      ALU_SUB: begin
        // The wrap into the extra bit is set exactly when a < b.
        result = diff[ALU_SIZE-1:0];
        carry  = diff[ALU_SIZE];
      end
      ALU_MUL:  result = product[ALU_SIZE-1:0];
      ALU_DIV:  result = quotient;
      ALU_SHL:  result = a << SHIFT_BIT;
      ALU_SHR:  result = a >> SHIFT_BIT;
      ALU_ROL:  result = rol;
      ALU_ROR:  result = ror;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_NAND: result = ~(a & b);
      ALU_XNOR: result = ~(a ^ b);
      ALU_GT:   result = {{(ALU_SIZE-1){1'b0}}, (a > b)};
      ALU_EQ:   result = {{(ALU_SIZE-1){1'b0}}, (a == b)};
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule : alu_comb

// File: rtl/alu_unit.sv
// alu_unit
//   Registered integer ALU for the MIPS datapath: 16 ops, one-cycle latency,
//   one op per cycle, no handshake.
//   Ports:
//     clk        in   1         clock, all state on rising edge
//     rst        in   1         synchronous active-high reset (clears outputs)
//     alu_in_a   in   ALU_SIZE  operand A (unsigned)
//     alu_in_b   in   ALU_SIZE  operand B (unsigned)
//     alu_sel    in   4         operation select (see alu_pkg::alu_op_e)
//     alu_out    out  ALU_SIZE  registered result
//     carry_out  out  1         registered carry (ADD) / borrow (SUB)
module alu_unit
  import alu_pkg::*;
#(
  parameter int ALU_SIZE  = 8,
  parameter int SHIFT_BIT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ALU_SIZE-1:0] alu_in_a,
  input  logic [ALU_SIZE-1:0] alu_in_b,
  input  logic [3:0]          alu_sel,
  output logic [ALU_SIZE-1:0] alu_out,
  output logic                carry_out
);

  logic [ALU_SIZE-1:0] result_next;
  logic                carry_next;
  logic [ALU_SIZE-1:0] result_reg;
  logic                carry_reg;

  alu_comb #(
    .ALU_SIZE  (ALU_SIZE),
    .SHIFT_BIT (SHIFT_BIT)
  ) u_alu_comb (
    .a      (alu_in_a),
    .b      (alu_in_b),
    .sel    (alu_op_e'(alu_sel)),
    .result (result_next),
    .carry  (carry_next)
  );

  // Reset takes priority and drops whatever op was sampled on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_reg <= '0;
      carry_reg  <= 1'b0;
    end else begin
      result_reg <= result_next;
      carry_reg  <= carry_next;
    end
  end

  assign alu_out   = result_reg;
  assign carry_out = carry_reg;

endmodule : alu_unit

// File: tb/tb_alu_unit.sv
module tb_alu_unit;

  localparam int N = 8;
  localparam int S = 1;

  logic         clk;
  logic         rst;
  logic [N-1:0] alu_in_a;
  logic [N-1:0] alu_in_b;
  logic [3:0]   alu_sel;
  logic [N-1:0] alu_out;
  logic         carry_out;

  int vectors;
  int miscompares;

  alu_unit #(
    .ALU_SIZE  (N),
    .SHIFT_BIT (S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_in_a  (alu_in_a),
    .alu_in_b  (alu_in_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: arithmetic straight from the op table, on plain integers.
  function automatic void ref_alu(input int unsigned a, input int unsigned b,
                                  input int unsigned sel,
                                  output int unsigned r, output int unsigned c);
    int unsigned mask;
    int unsigned s;
    mask = (32'd1 << N) - 1;
    c = 0;
    case (sel)
      0: begin s = a + b; r = s & mask; c = (s > mask) ? 1 : 0; end
      1: begin r = (a - b) & mask; c = (a < b) ? 1 : 0; end
      2: r = (a * b) & mask;
      3: r = (b == 0) ? mask : a / b;
      4: r = (a << S) & mask;
      5: r = a >> S;
      6: r = ((a << S) | (a >> (N - S))) & mask;
      7: r = ((a >> S) | (a << (N - S))) & mask;
      8: r = a & b;
      9: r = a | b;
      10: r = a ^ b;
      11: r = ~(a | b) & mask;
      12: r = ~(a & b) & mask;
      13: r = ~(a ^ b) & mask;
      14: r = (a > b) ? 1 : 0;
      default: r = (a == b) ? 1 : 0;
    endcase
  endfunction

  // Drive one op and let one rising edge capture it; sample 1 time unit later.
  task automatic apply(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] sel);
    alu_in_a = a;
    alu_in_b = b;
    alu_sel  = sel;
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [3:0] sel, input logic [N-1:0] exp_r, input logic exp_c);
    apply(a, b, sel);
    check({tag, ".out"}, 32'(alu_out), 32'(exp_r));
    check({tag, ".carry"}, 32'(carry_out), 32'(exp_c));
    $display("op %-10s a=%02h b=%02h sel=%0d -> out=%02h c=%0d", tag, a, b, sel, alu_out, carry_out);
  endtask

  logic [N-1:0] sweep_exp [16];

  initial begin
    int unsigned er;
    int unsigned ec;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic [3:0]   rs;
    logic         rr;

    vectors     = 0;
    miscompares = 0;
    sweep_exp = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                  8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};

    rst = 1'b1;
    alu_in_a = '0;
    alu_in_b = '0;
    alu_sel  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.out", 32'(alu_out), 32'h0);
    check("reset.carry", 32'(carry_out), 32'h0);
    $display("reset -> out=%02h c=%0d", alu_out, carry_out);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      logic [3:0] sel_i;
      sel_i = 4'(i);
      directed($sformatf("sweep%0d", i), 8'h0A, 8'h02, sel_i, sweep_exp[i], 1'b0);
    end

    directed("add_carry", 8'hF6, 8'h0A, 4'd0, 8'h00, 1'b1);
    directed("sub_borrow", 8'h0A, 8'hF6, 4'd1, 8'h14, 1'b1);
    directed("rol81", 8'h81, 8'h00, 4'd6, 8'h03, 1'b0);
    directed("ror81", 8'h81, 8'h00, 4'd7, 8'hC0, 1'b0);
    directed("shl81", 8'h81, 8'h00, 4'd4, 8'h02, 1'b0);
    directed("shr81", 8'h81, 8'h00, 4'd5, 8'h40, 1'b0);
    directed("div_zero", 8'h37, 8'h00, 4'd3, 8'hFF, 1'b0);
    directed("eq_same", 8'h37, 8'h37, 4'd15, 8'h01, 1'b0);

    // Reset mid-stream: the ADD sampled under rst must be discarded.
    rst = 1'b1;
    directed("rst_hold", 8'hF6, 8'h0A, 4'd0, 8'h00, 1'b0);
    rst = 1'b0;
    directed("rst_release", 8'hF6, 8'h0A, 4'd0, 8'h00, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rs = 4'($urandom);
      if ($urandom_range(0, 3) == 0) rb = N'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) rb = ra;
      rr = ($urandom_range(0, 49) == 0);
      rst = rr;
      ref_alu(32'(ra), 32'(rb), 32'(rs), er, ec);
      if (rr) begin
        er = 0;
        ec = 0;
      end
      apply(ra, rb, rs);
      check($sformatf("rand%0d.out", i), 32'(alu_out), er);
      check($sformatf("rand%0d.carry", i), 32'(carry_out), ec);
      if ((i % 1000) == 999)
        $display("random block ending %0d: last a=%02h b=%02h sel=%0d rst=%0d -> out=%02h c=%0d",
                 i, ra, rb, rs, rr, alu_out, carry_out);
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_alu_unit
